// File: rtl/bidir_pkg.sv
// Shared types and helpers for the half-duplex turnaround controller.
// Holds the FSM state encoding and the turnaround counter sizing function.
package bidir_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN_OUT = 2'd1,
    DRIVE    = 2'd2,
    TURN_IN  = 2'd3
  } bidir_state_t;

  // Counter must hold the value TA; a zero-length turnaround still needs one bit.
  function automatic int cnt_width(input int ta);
    int w;
    w = $clog2(ta + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bidir_sync.sv
// Receive synchronizer: SYNC_STAGES-deep flop chain on the bus plus a
// saturating fill counter that declares the sample settled once the chain has refilled.
module bidir_sync #(
  parameter int W           = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] data,
  output logic         valid
);

  localparam int            FW   = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0] FULL = FW'(SYNC_STAGES);

  logic [FW-1:0] fill_reg;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
    logic [W-1:0] q_reg;
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst) q_reg <= '0;
        else     q_reg <= d;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (rst) q_reg <= '0;
        else     q_reg <= g_stage[gi-1].q_reg;
      end
    end
  end

  assign data = g_stage[SYNC_STAGES-1].q_reg;

  // Clearing only the fill count is enough: stale chain contents are masked by valid.
  always_ff @(posedge clk) begin
    if (rst || clr)        fill_reg <= '0;
    else if (fill_reg != FULL) fill_reg <= fill_reg + FW'(1);
  end

  assign valid = (fill_reg == FULL);

endmodule

// File: rtl/bidir_turnaround_ctrl.sv
// Half-duplex bus owner: drives transmit bursts onto a shared tri-state bus with
// hi-Z turnaround gaps around each drive window, and listens through a synchronizer when idle.
module bidir_turnaround_ctrl
  import bidir_pkg::*;
#(
  parameter int W           = 1,
  parameter int TA          = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire  [W-1:0] io,
  input  logic         tx_valid,
  input  logic [W-1:0] tx_data,
  input  logic         tx_last,
  output logic         tx_ready,
  output logic         rx_valid,
  output logic [W-1:0] rx_data,
  output logic         oe,
  output logic         busy
);

  localparam int            CW      = cnt_width(TA);
  localparam logic [CW-1:0] TA_LAST = CW'(TA);

  bidir_state_t  state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [W-1:0]  out_reg, out_next;
  logic          oe_reg, oe_next;
  logic          busy_reg;
  logic          sync_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      out_reg   <= '0;
      oe_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      oe_reg    <= oe_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    oe_next    = oe_reg;
    tx_ready   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        oe_next = 1'b0;
        if (tx_valid) begin
          if (TA == 0) begin
            state_next = DRIVE;
            cnt_next   = '0;
          end else begin
            // TURN_OUT counts 1..TA so that it lasts exactly TA cycles.
            state_next = TURN_OUT;
            cnt_next   = CW'(1);
          end
        end
      end
      TURN_OUT: begin
        oe_next = 1'b0;
        if (cnt_reg == TA_LAST) begin
          state_next = DRIVE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DRIVE: begin
        tx_ready = 1'b1;
        // Bubbles keep out/oe untouched so the bus stays driven mid-burst.
        if (tx_valid) begin
          out_next = tx_data;
          oe_next  = 1'b1;
          if (tx_last) begin
            state_next = TURN_IN;
            cnt_next   = '0;
          end
        end
      end
      TURN_IN: begin
        // First TURN_IN cycle still shows the last word; release at its closing edge.
        oe_next = 1'b0;
        if (cnt_reg == TA_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        oe_next    = 1'b0;
      end
    endcase
  end

  assign io   = oe_reg ? out_reg : {W{1'bz}};
  assign oe   = oe_reg;
  assign busy = busy_reg;

  // Clear on leaving IDLE (same edge) and on the edge that re-enters it, so the
  // chain fully refills with peer data before rx_valid returns.
  assign sync_clr = (state_reg != IDLE) || (state_next != IDLE);

  bidir_sync #(
    .W           (W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .clr   (sync_clr),
    .d     (io),
    .data  (rx_data),
    .valid (rx_valid)
  );

endmodule

// File: tb/tb_bidir_turnaround_ctrl.sv
// Directed bench: one controller with TA=2 (peer attached to its bus) and one with TA=0.
module tb_bidir_turnaround_ctrl;
  import bidir_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] tx_data = '0;
  logic         tx_last = 1'b0;

  logic         tx_valid_a = 1'b0, tx_ready_a, rx_valid_a, oe_a, busy_a;
  logic [W-1:0] rx_data_a;
  logic         tx_valid_b = 1'b0, tx_ready_b, rx_valid_b, oe_b, busy_b;
  logic [W-1:0] rx_data_b;
  wire  [W-1:0] io_a, io_b;

  logic         peer_oe  = 1'b0;
  logic [W-1:0] peer_val = '0;
  assign io_a = peer_oe ? peer_val : {W{1'bz}};

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bidir_turnaround_ctrl #(.W(W), .TA(2), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst(rst), .io(io_a), .tx_valid(tx_valid_a), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(tx_ready_a), .rx_valid(rx_valid_a),
    .rx_data(rx_data_a), .oe(oe_a), .busy(busy_a)
  );

  bidir_turnaround_ctrl #(.W(W), .TA(0), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst(rst), .io(io_b), .tx_valid(tx_valid_b), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(tx_ready_b), .rx_valid(rx_valid_b),
    .rx_data(rx_data_b), .oe(oe_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    step(3);
    check("rst_oe_a", W'(oe_a), 8'h00);
    check("rst_ready_a", W'(tx_ready_a), 8'h00);
    check("rst_rxv_a", W'(rx_valid_a), 8'h00);
    check("rst_busy_a", W'(busy_a), 8'h00);
    check("rst_oe_b", W'(oe_b), 8'h00);
    check("rst_busy_b", W'(busy_b), 8'h00);
    rst = 1'b0; peer_oe = 1'b1; peer_val = 8'h00;
    step(1);
    check("rst_rxv_1cyc", W'(rx_valid_a), 8'h00);
    step(1);
    check("rst_rxv_2cyc", W'(rx_valid_a), 8'h01);
    check("rst_rxdata", rx_data_a, 8'h00);
    $display("txn reset: released, receive path settled");

    // ---------------- receive, then single-word burst A5 ----------------
    peer_val = 8'hC3;
    step(2);
    check("rx_valid_c3", W'(rx_valid_a), 8'h01);
    check("rx_data_c3", rx_data_a, 8'hC3);
    peer_oe = 1'b0;
    tx_valid_a = 1'b1; tx_data = 8'hA5; tx_last = 1'b1;
    step(1);  // cycle 1
    check("sw_rxv_drop", W'(rx_valid_a), 8'h00);
    check("sw_state_c1", W'(u_a.state_reg), W'(TURN_OUT));
    check("sw_ready_c1", W'(tx_ready_a), 8'h00);
    check("sw_busy_c1", W'(busy_a), 8'h01);
    step(1);  // cycle 2
    check("sw_state_c2", W'(u_a.state_reg), W'(TURN_OUT));
    check("sw_oe_c2", W'(oe_a), 8'h00);
    step(1);  // cycle 3
    check("sw_ready_c3", W'(tx_ready_a), 8'h01);
    check("sw_oe_c3", W'(oe_a), 8'h00);
    step(1);  // cycle 4: word on bus
    tx_valid_a = 1'b0; tx_last = 1'b0;
    check("sw_oe_c4", W'(oe_a), 8'h01);
    check("sw_io_c4", io_a, 8'hA5);
    check("sw_ready_c4", W'(tx_ready_a), 8'h00);
    step(1);  // cycle 5
    check("sw_oe_c5", W'(oe_a), 8'h00);
    check("sw_busy_c5", W'(busy_a), 8'h01);
    step(1);  // cycle 6
    check("sw_busy_c6", W'(busy_a), 8'h01);
    step(1);  // cycle 7: back in IDLE
    check("sw_busy_c7", W'(busy_a), 8'h00);
    check("sw_rxv_c7", W'(rx_valid_a), 8'h00);
    peer_oe = 1'b1; peer_val = 8'hC3;
    step(1);
    check("sw_rxv_c8", W'(rx_valid_a), 8'h00);
    step(1);
    check("sw_rxv_c9", W'(rx_valid_a), 8'h01);
    check("sw_rxdata_c9", rx_data_a, 8'hC3);
    peer_oe = 1'b0;
    $display("txn single-word A5 (TA=2) with receive gating");

    // ---------------- burst with bubble 11, gap, 22 ----------------
    tx_valid_a = 1'b1; tx_data = 8'h11; tx_last = 1'b0;
    step(4);  // handshake at edge 4
    check("bb_io_11", io_a, 8'h11);
    check("bb_oe_11", W'(oe_a), 8'h01);
    tx_valid_a = 1'b0; tx_data = 8'hEE; tx_last = 1'b1;  // stray last without valid
    step(1);
    check("bb_io_gap1", io_a, 8'h11);
    check("bb_state_gap1", W'(u_a.state_reg), W'(DRIVE));
    tx_last = 1'b0;
    step(1);
    check("bb_io_gap2", io_a, 8'h11);
    check("bb_oe_gap2", W'(oe_a), 8'h01);
    tx_valid_a = 1'b1; tx_data = 8'h22; tx_last = 1'b1;
    step(1);
    tx_valid_a = 1'b0; tx_last = 1'b0;
    check("bb_io_22", io_a, 8'h22);
    check("bb_state_22", W'(u_a.state_reg), W'(TURN_IN));
    step(1);
    check("bb_oe_rel", W'(oe_a), 8'h00);
    step(2);
    check("bb_busy_end", W'(busy_a), 8'h00);
    $display("txn burst 11,gap,22 (TA=2)");

    // ---------------- TA=0 single word 3C ----------------
    tx_valid_b = 1'b1; tx_data = 8'h3C; tx_last = 1'b1;
    step(1);
    check("t0_state_c1", W'(u_b.state_reg), W'(DRIVE));
    check("t0_ready_c1", W'(tx_ready_b), 8'h01);
    check("t0_oe_c1", W'(oe_b), 8'h00);
    step(1);
    tx_valid_b = 1'b0; tx_last = 1'b0;
    check("t0_io_c2", io_b, 8'h3C);
    check("t0_oe_c2", W'(oe_b), 8'h01);
    step(1);
    check("t0_oe_c3", W'(oe_b), 8'h00);
    check("t0_state_c3", W'(u_b.state_reg), W'(IDLE));
    check("t0_busy_c3", W'(busy_b), 8'h00);
    $display("txn single-word 3C (TA=0)");

    // ---------------- reset mid-DRIVE ----------------
    tx_valid_a = 1'b1; tx_data = 8'h5A; tx_last = 1'b0;
    step(4);
    check("rd_io_5a", io_a, 8'h5A);
    rst = 1'b1;
    step(1);
    rst = 1'b0; tx_valid_a = 1'b0;
    check("rd_oe", W'(oe_a), 8'h00);
    check("rd_state", W'(u_a.state_reg), W'(IDLE));
    check("rd_ready", W'(tx_ready_a), 8'h00);
    step(2);
    check("rd_ready_after", W'(tx_ready_a), 8'h00);
    check("rd_busy_after", W'(busy_a), 8'h00);
    $display("txn reset during DRIVE 5A");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
